move_cmd_scheduler: RTL and testbench
=====================================

MOVE_CMD_SCHEDULER -- requirements
Module: move_cmd_scheduler

Interface
REQ-001 SHALL have parameter DEPTH, default 4: command FIFO entries, power of two, 2..16.
REQ-002 SHALL have parameter INIT_TICKS, default 3: tick pulses spent in INIT before MOVE.
REQ-003 SHALL have parameter FALL_TICKS, default 1: tick pulses spent in FALL before INIT.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on posedge clk.
REQ-005 SHALL have port rst  in  1  one clock; reset is asynchronous and active-low (rst=0 resets).
REQ-006 SHALL have port tick  in  1  single-cycle timebase enable pulse.
REQ-007 SHALL have ports btn_right, btn_left, btn_up, btn_down  in  1 each  debounced single-cycle button pulses.
REQ-008 SHALL have port cmd_valid  out  1  FIFO head holds a command.
REQ-009 SHALL have port cmd_code  out  2  head command: 0 RIGHT, 1 LEFT, 2 UP.
REQ-010 SHALL have port cmd_ready  in  1  consumer accepts head this cycle.
REQ-011 SHALL have port phase  out  2  00 INIT, 01 MOVE, 10 FALL.
REQ-012 SHALL have port fall_start  out  1  one-cycle pulse on MOVE->FALL.
REQ-013 SHALL have port drop  out  1  one-cycle pulse when any asserted button pulse is discarded.
REQ-014 SHALL have port fifo_count  out  $clog2(DEPTH)+1  occupied entries.
REQ-015 SHALL have port overflow  out  1  sticky: a push was lost to a full FIFO.

Function
REQ-016 SHALL implement phase FSM INIT->MOVE->FALL->INIT; encoding 11 unreachable, decodes to INIT next cycle.
REQ-017 SHALL clear the tick counter in the cycle phase changes; tick in that same cycle not counted.
REQ-018 SHALL move INIT->MOVE on the cycle the INIT_TICKS-th counted tick is sampled; phase reads MOVE next cycle.
REQ-019 SHALL move MOVE->FALL when btn_down=1 in MOVE; fall_start=1 in the cycle phase first reads FALL.
REQ-020 SHALL move FALL->INIT on the FALL_TICKS-th counted tick in FALL.
REQ-021 SHALL treat btn_down in INIT or FALL as discarded (drop=1 next cycle); btn_down never enters FIFO.
REQ-022 SHALL arbitrate same-cycle pulses by fixed priority down > right > left > up; at most one action per cycle; every loser discarded.
REQ-023 SHALL push the winning right/left/up code in MOVE and FALL; discard all pulses in INIT.
REQ-024 SHALL be first-word-fall-through: cmd_valid=(fifo_count!=0), cmd_code=head; pop when cmd_valid&cmd_ready.
REQ-025 SHALL, on push with fifo_count=DEPTH and no pop, discard the push, set overflow, pulse drop.
REQ-026 SHALL, on push and pop in the same cycle (including when full), accept both; count unchanged.
REQ-027 SHALL leave cmd_code stable while cmd_valid=1 and cmd_ready=0.
REQ-028 SHALL flush FIFO on FALL->INIT: a pop in that cycle completes, remaining entries and any push discarded; fifo_count=0 next cycle.
REQ-029 SHALL keep FIFO contents across MOVE->FALL.
REQ-030 SHALL register drop and fall_start; each high exactly one cycle per event, one cycle after the causing input.
REQ-031 SHALL wrap FIFO pointers modulo DEPTH with no entry loss or duplication.

Reset
REQ-032 SHALL, while rst=0, force phase=INIT, cmd_valid=0, cmd_code=0, fifo_count=0, fall_start=0, drop=0, overflow=0, tick counter=0.
REQ-033 SHALL clear overflow only by reset.
REQ-034 SHALL, on reset mid-operation, discard all FIFO entries and restart INIT tick counting after release.

Verification
REQ-035 SHALL cover: release reset, 3 ticks -> phase 00 until 3rd tick sampled, 01 next cycle; button pulses before then -> drop=1, fifo_count=0.
REQ-036 SHALL cover: MOVE, right/left/up pulses, cmd_ready=0 -> fifo_count=3, codes 0,1,2 popped in order once cmd_ready=1.
REQ-037 SHALL cover: MOVE, right+down same cycle -> phase=10, fall_start=1 once, drop=1 once, fifo_count unchanged.
REQ-038 SHALL cover: DEPTH=4, 5 pushes, cmd_ready=0 -> fifo_count=4, overflow=1; then push+pop together -> count stays 4.
REQ-039 SHALL cover: FALL with 2 entries, 1 tick -> phase=00, fifo_count=0, cmd_valid=0 next cycle.
REQ-040 SHALL cover: rst=0 asserted mid-FALL with 3 entries -> all outputs at reset values immediately, no clock required.

Source files
------------

// File: rtl/move_cmd_scheduler.sv
// Movement command scheduler: a phase FSM (INIT/MOVE/FALL) paced by tick pulses,
// plus a first-word-fall-through FIFO of right/left/up commands for a downstream consumer.
module move_cmd_scheduler #(
  parameter int DEPTH      = 4,
  parameter int INIT_TICKS = 3,
  parameter int FALL_TICKS = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick,
  input  logic                     btn_right,
  input  logic                     btn_left,
  input  logic                     btn_up,
  input  logic                     btn_down,
  output logic                     cmd_valid,
  output logic [1:0]               cmd_code,
  input  logic                     cmd_ready,
  output logic [1:0]               phase,
  output logic                     fall_start,
  output logic                     drop,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = 8;

  localparam logic [1:0] PH_INIT = 2'b00;
  localparam logic [1:0] PH_MOVE = 2'b01;
  localparam logic [1:0] PH_FALL = 2'b10;

  localparam logic [1:0] CODE_RIGHT = 2'd0;
  localparam logic [1:0] CODE_LEFT  = 2'd1;
  localparam logic [1:0] CODE_UP    = 2'd2;

  logic [1:0]    phase_q, phase_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          fall_q, fall_d;
  logic          drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic [1:0]    mem_q [DEPTH];

  logic          win_down, win_right, win_left, win_up;
  logic          any_btn, lost;
  logic [2:0]    n_btn;
  logic          push, push_ok, pop, full, flush;
  logic [1:0]    push_code;

  // Fixed priority down > right > left > up; any second asserted pulse is a loser.
  assign win_down  = btn_down;
  assign win_right = btn_right & ~btn_down;
  assign win_left  = btn_left & ~btn_down & ~btn_right;
  assign win_up    = btn_up & ~btn_down & ~btn_right & ~btn_left;
  assign n_btn     = 3'(btn_right) + 3'(btn_left) + 3'(btn_up) + 3'(btn_down);
  assign any_btn   = (n_btn != 3'd0);
  assign lost      = (n_btn > 3'd1);
  assign push_code = win_right ? CODE_RIGHT : (win_left ? CODE_LEFT : CODE_UP);

  // Consumer handshake: a command transfers in any cycle where cmd_valid and
  // cmd_ready are both high; cmd_code holds steady while valid waits for ready.
  assign pop  = cmd_valid & cmd_ready;
  assign full = (count_q == CW'(DEPTH));

  always_comb begin
    phase_d = phase_q;
    tcnt_d  = tcnt_q;
    fall_d  = 1'b0;
    drop_d  = 1'b0;
    push    = 1'b0;
    flush   = 1'b0;
    case (phase_q)
      PH_INIT: begin
        drop_d = any_btn;
        if (tick) begin
          if (tcnt_q == TW'(INIT_TICKS - 1)) begin
            phase_d = PH_MOVE;
            tcnt_d  = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      PH_MOVE: begin
        tcnt_d = '0;
        drop_d = lost;
        if (win_down) begin
          phase_d = PH_FALL;
          fall_d  = 1'b1;
        end else begin
          push = win_right | win_left | win_up;
        end
      end
      PH_FALL: begin
        drop_d = lost | win_down;
        push   = win_right | win_left | win_up;
        if (tick) begin
          if (tcnt_q == TW'(FALL_TICKS - 1)) begin
            phase_d = PH_INIT;
            tcnt_d  = '0;
            flush   = 1'b1;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: begin
        phase_d = PH_INIT;
        tcnt_d  = '0;
        drop_d  = any_btn;
      end
    endcase

    push_ok = push & ~flush & (~full | pop);
    ovf_d   = ovf_q;
    if (push & ~flush & full & ~pop) begin
      ovf_d  = 1'b1;
      drop_d = 1'b1;
    end
    if (push & flush) drop_d = 1'b1;

    // A pop in the flush cycle still completes; everything left is discarded.
    if (flush) begin
      rd_d    = '0;
      wr_d    = '0;
      count_d = '0;
    end else begin
      rd_d    = rd_q + AW'(pop);
      wr_d    = wr_q + AW'(push_ok);
      count_d = count_q + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= PH_INIT;
      tcnt_q  <= '0;
      fall_q  <= 1'b0;
      drop_q  <= 1'b0;
      ovf_q   <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      phase_q <= phase_d;
      tcnt_q  <= tcnt_d;
      fall_q  <= fall_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= push_code;
  end

  assign cmd_valid  = (count_q != '0);
  assign cmd_code   = cmd_valid ? mem_q[rd_q] : 2'd0;
  assign phase      = phase_q;
  assign fall_start = fall_q;
  assign drop       = drop_q;
  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_move_cmd_scheduler.sv
// Directed bench for move_cmd_scheduler: phase sequencing, FIFO ordering,
// overflow, flush on FALL->INIT and asynchronous reset.
module tb_move_cmd_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       btn_right = 1'b0, btn_left = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
  logic       cmd_ready = 1'b0;
  logic       cmd_valid;
  logic [1:0] cmd_code;
  logic [1:0] phase;
  logic       fall_start, drop, overflow;
  logic [2:0] fifo_count;

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [1:0] exp_q[$];

  move_cmd_scheduler #(.DEPTH(4), .INIT_TICKS(3), .FALL_TICKS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .btn_right  (btn_right),
    .btn_left   (btn_left),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .cmd_ready  (cmd_ready),
    .phase      (phase),
    .fall_start (fall_start),
    .drop       (drop),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic btn(input logic r, input logic l, input logic u, input logic d);
    {btn_right, btn_left, btn_up, btn_down} = {r, l, u, d};
    cyc();
    {btn_right, btn_left, btn_up, btn_down} = 4'b0000;
  endtask

  // Single accepted push: the scoreboard learns the code when it is driven.
  task automatic push_cmd(input logic [1:0] code);
    exp_q.push_back(code);
    case (code)
      2'd0:    btn(1'b1, 1'b0, 1'b0, 1'b0);
      2'd1:    btn(1'b0, 1'b1, 1'b0, 1'b0);
      default: btn(1'b0, 1'b0, 1'b1, 1'b0);
    endcase
  endtask

  task automatic pop_one(input string tag);
    logic [1:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b11;
    chk({tag, "_valid"}, 8'(cmd_valid), 8'd1);
    chk({tag, "_code"}, 8'(cmd_code), 8'(e));
    cmd_ready = 1'b1;
    cyc();
    cmd_ready = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_phase"}, 8'(phase), 8'd0);
    chk({tag, "_valid"}, 8'(cmd_valid), 8'd0);
    chk({tag, "_code"}, 8'(cmd_code), 8'd0);
    chk({tag, "_count"}, 8'(fifo_count), 8'd0);
    chk({tag, "_fall"}, 8'(fall_start), 8'd0);
    chk({tag, "_drop"}, 8'(drop), 8'd0);
    chk({tag, "_ovf"}, 8'(overflow), 8'd0);
  endtask

  // Two counted ticks, then the third: phase must flip only after it is sampled.
  task automatic ticks_to_move(input string tag);
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
    tick = 1'b1; cyc(); tick = 1'b0; cyc();
    chk({tag, "_init2"}, 8'(phase), 8'd0);
    tick = 1'b1;
    chk({tag, "_init3"}, 8'(phase), 8'd0);
    cyc();
    tick = 1'b0;
    chk({tag, "_move"}, 8'(phase), 8'd1);
  endtask

  initial begin
    logic [1:0] e;
    repeat (3) @(posedge clk);
    #1;
    check_reset("rst0");
    rst = 1'b1;
    cyc();

    // Buttons in INIT are discarded
    btn(1'b1, 1'b0, 1'b0, 1'b0);
    chk("init_drop", 8'(drop), 8'd1);
    chk("init_count", 8'(fifo_count), 8'd0);
    cyc();
    chk("init_drop_clr", 8'(drop), 8'd0);
    btn(1'b0, 1'b0, 1'b0, 1'b1);
    chk("init_down_drop", 8'(drop), 8'd1);
    chk("init_down_phase", 8'(phase), 8'd0);
    ticks_to_move("t1");

    // Ordered FIFO with consumer stalled
    push_cmd(2'd0);
    push_cmd(2'd1);
    push_cmd(2'd2);
    chk("fifo3_count", 8'(fifo_count), 8'd3);
    chk("fifo3_drop", 8'(drop), 8'd0);
    cyc();
    chk("stall_code", 8'(cmd_code), 8'd0);
    pop_one("pop_a");
    pop_one("pop_b");
    pop_one("pop_c");
    chk("fifo_empty", 8'(fifo_count), 8'd0);
    chk("fifo_empty_valid", 8'(cmd_valid), 8'd0);

    // Overflow, then simultaneous push+pop when full (pointers wrap here)
    push_cmd(2'd0);
    push_cmd(2'd1);
    push_cmd(2'd2);
    push_cmd(2'd0);
    chk("full_count", 8'(fifo_count), 8'd4);
    chk("full_ovf_pre", 8'(overflow), 8'd0);
    btn(1'b0, 1'b1, 1'b0, 1'b0);
    chk("ovf_drop", 8'(drop), 8'd1);
    chk("ovf_flag", 8'(overflow), 8'd1);
    chk("ovf_count", 8'(fifo_count), 8'd4);
    e = exp_q.pop_front();
    chk("pp_code", 8'(cmd_code), 8'(e));
    btn_up = 1'b1;
    cmd_ready = 1'b1;
    exp_q.push_back(2'd2);
    cyc();
    btn_up = 1'b0;
    cmd_ready = 1'b0;
    chk("pp_count", 8'(fifo_count), 8'd4);
    chk("pp_drop", 8'(drop), 8'd0);
    pop_one("drain_a");
    pop_one("drain_b");
    pop_one("drain_c");
    pop_one("drain_d");
    chk("drain_count", 8'(fifo_count), 8'd0);
    chk("ovf_sticky", 8'(overflow), 8'd1);

    // right+down in MOVE: fall wins, right dropped, FIFO kept
    push_cmd(2'd0);
    push_cmd(2'd1);
    btn(1'b1, 1'b0, 1'b0, 1'b1);
    chk("fall_phase", 8'(phase), 8'd2);
    chk("fall_start", 8'(fall_start), 8'd1);
    chk("fall_drop", 8'(drop), 8'd1);
    chk("fall_count", 8'(fifo_count), 8'd2);
    cyc();
    chk("fall_start_once", 8'(fall_start), 8'd0);
    chk("fall_drop_once", 8'(drop), 8'd0);
    chk("fall_hold", 8'(phase), 8'd2);

    // One tick in FALL flushes and returns to INIT
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    chk("flush_phase", 8'(phase), 8'd0);
    chk("flush_count", 8'(fifo_count), 8'd0);
    chk("flush_valid", 8'(cmd_valid), 8'd0);
    exp_q.delete();

    // Second pass: pushes in FALL, down in FALL dropped, then async reset
    ticks_to_move("t2");
    push_cmd(2'd1);
    push_cmd(2'd2);
    btn(1'b0, 1'b0, 1'b0, 1'b1);
    chk("fall2_phase", 8'(phase), 8'd2);
    push_cmd(2'd0);
    chk("fall2_push", 8'(fifo_count), 8'd3);
    btn(1'b0, 1'b0, 1'b0, 1'b1);
    chk("fall2_down_drop", 8'(drop), 8'd1);
    chk("fall2_down_phase", 8'(phase), 8'd2);
    chk("fall2_code", 8'(cmd_code), 8'(exp_q[0]));
    #2;
    rst = 1'b0;
    #1;
    check_reset("rst_mid");
    exp_q.delete();
    cyc();
    rst = 1'b1;
    cyc();
    ticks_to_move("t3");
    chk("post_rst_count", 8'(fifo_count), 8'd0);
    chk("post_rst_ovf", 8'(overflow), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
